basys3_7seg_capture: RTL and testbench
======================================

BASYS3_7SEG_CAPTURE -- requirements
Module: basys3_7seg_capture

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 8, clk_1k_i cycles without a refresh before a digit is declared disabled (legal range 5..255).
REQ-002 Port: clk_1k_i  input  1  sole clock, the 1 kHz display scan clock.
REQ-003 Port: rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 Port: anode_i  input  4  multiplexed display anodes, active-low, bit N selects digit N.
REQ-005 Port: segments_i  input  7  cathodes, active-low, bit0=A ... bit6=G.
REQ-006 Ports: digitN_en_o  output  1, N=0..3  digit N is currently being refreshed by the display source.
REQ-007 Ports: digitN_o  output  4, N=0..3  last hex value decoded for digit N.
REQ-008 Port: frame_o  output  1  one-cycle pulse on scan wrap-around.
REQ-009 Port: err_o  output  1  one-cycle pulse on an illegal anode or segment sample.
REQ-010 Port: err_sticky_o  output  1  set by any error, cleared only by reset.

Function
REQ-011 The block SHALL register anode_i and segments_i on every rising clk_1k_i edge (capture stage).
REQ-012 The block SHALL update all outputs from the captured sample on the following edge, giving a 2-edge input-to-output latency.
REQ-013 Anode classification: exactly one bit low selects an active index; 4'b1111 means idle; two or more bits low is an anode error.
REQ-014 Segment decode: the inverted segments SHALL be matched against the 16-entry hex pattern table (0-F, standard gfedcba shapes, 6=7'h7D, 7=7'h07, 9=7'h6F).
REQ-015 Active index with a pattern in the table (an accept) SHALL load digitN_o, set digitN_en_o=1 and clear that digit's timeout counter.
REQ-016 Active index with all segments off SHALL clear digitN_en_o, leave digitN_o unchanged and raise no error.
REQ-017 Active index with any other pattern is a segment error: outputs and timeout counters unchanged.
REQ-018 Anode error SHALL leave every digit output and timeout counter unchanged, regardless of the segment value.
REQ-019 Every error SHALL pulse err_o for exactly one cycle and set err_sticky_o.
REQ-020 Idle samples SHALL change no digit state.
REQ-021 Each digit SHALL have a saturating timeout counter that increments every cycle in which that digit is not accepted.
REQ-022 When a counter reaches TIMEOUT_CYCLES, the block SHALL clear that digit's digitN_en_o; digitN_o holds its value.
REQ-023 The block SHALL track the last accepted index (invalid after reset).
REQ-024 An accept of index i <= the last accepted index SHALL pulse frame_o for one cycle.
REQ-025 The first accept after reset SHALL NOT pulse frame_o.
REQ-026 Accept and timeout expiry in the same cycle for the same digit: the accept wins.

Reset
REQ-027 While rst_ni=0 the block SHALL asynchronously clear all outputs, the capture registers, all timeout counters and err_sticky_o, and mark the last accepted index invalid.
REQ-028 Release of rst_ni SHALL be synchronous to clk_1k_i.
REQ-029 Reset asserted mid-scan SHALL discard any partially captured frame.

Structure
REQ-030 Shared package basys3_7seg_pkg SHALL hold:
- SEG_PATTERNS, the 16x7 active-high table
- SEG_BLANK
- the 2-bit digit_idx_t typedef
- the anode one-hot-low constants
REQ-031 Decoding SHALL live in one combinational sub-module, seg7_pattern_decode: 7-bit pattern in; 4-bit value, valid and blank flags out.

Verification
REQ-032 anode_i=1110, segments_i=7'b0010010 (a "5") -> two edges later digit0_o=5, digit0_en_o=1, err_o=0.
REQ-033 Rotate digits 0..3 showing 1,2,3,4, one per cycle, twice:
- outputs read 1,2,3,4 with all enables 1
- frame_o pulses once at each 3->0 wrap
- no frame_o pulse in the first pass
REQ-034 Same rotation, but digit 2's slot driven as anode_i=1111 -> digit2_en_o falls once its counter reaches 8, other enables stay 1, digit2_o holds 3.
REQ-035 Error cases, each -> err_o single pulse, err_sticky_o=1, digit outputs unchanged:
- anode_i=1100
- anode_i=1110 with segments_i=7'b1111110 (only A lit)
REQ-036 rst_ni pulsed low between clock edges mid-rotation -> all outputs and err_sticky_o read 0 before the next edge; after release, the first accept produces no frame_o pulse.

Source files
------------

// File: rtl/basys3_7seg_pkg.sv
// Shared constants and types for the Basys3 seven-segment display capture block.
package basys3_7seg_pkg;

    typedef logic [1:0] digit_idx_t;

    // Active-high gfedcba shapes for hex digits 0..F
    localparam logic [6:0] SEG_PATTERNS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] ANODE_IDLE   = 4'b1111;
    localparam logic [3:0] ANODE_DIGIT0 = 4'b1110;
    localparam logic [3:0] ANODE_DIGIT1 = 4'b1101;
    localparam logic [3:0] ANODE_DIGIT2 = 4'b1011;
    localparam logic [3:0] ANODE_DIGIT3 = 4'b0111;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational lookup of an active-high segment pattern into a hex value.
module seg7_pattern_decode
    import basys3_7seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] value,
    output logic       valid,
    output logic       blank
);

    always_comb begin
        value = '0;
        valid = 1'b0;
        blank = (pattern == SEG_BLANK);
        for (int i = 0; i < 16; i++) begin
            if (pattern == SEG_PATTERNS[i]) begin
                value = 4'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/basys3_7seg_capture.sv
// Recovers per-digit hex values from a multiplexed active-low 7-segment scan.
module basys3_7seg_capture
    import basys3_7seg_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 8
) (
    input  logic       clk_1k_i,
    input  logic       rst_ni,
    input  logic [3:0] anode_i,
    input  logic [6:0] segments_i,
    output logic       digit0_en_o,
    output logic       digit1_en_o,
    output logic       digit2_en_o,
    output logic       digit3_en_o,
    output logic [3:0] digit0_o,
    output logic [3:0] digit1_o,
    output logic [3:0] digit2_o,
    output logic [3:0] digit3_o,
    output logic       frame_o,
    output logic       err_o,
    output logic       err_sticky_o
);

    localparam logic [7:0] CNT_MAX = 8'(TIMEOUT_CYCLES);

    logic [3:0] anode_q;
    logic [6:0] seg_q;
    logic       cap_vld_q;

    logic [3:0] en_q, en_d;
    logic [3:0] val_q [4];
    logic [3:0] val_d [4];
    logic [7:0] cnt_q [4];
    logic [7:0] cnt_d [4];
    digit_idx_t last_idx_q, last_idx_d;
    logic       last_vld_q, last_vld_d;
    logic       frame_q, frame_d;
    logic       err_q, err_d;
    logic       sticky_q, sticky_d;

    logic [6:0] pattern;
    logic [3:0] dec_value;
    logic       dec_valid, dec_blank;
    logic       sel, anode_err, accept, blank_sel, any_err;
    digit_idx_t idx;

    assign pattern = ~seg_q;

    seg7_pattern_decode u_decode (
        .pattern (pattern),
        .value   (dec_value),
        .valid   (dec_valid),
        .blank   (dec_blank)
    );

    always_comb begin
        sel       = 1'b0;
        idx       = '0;
        anode_err = 1'b0;
        unique case (anode_q)
            ANODE_IDLE:   ;
            ANODE_DIGIT0: begin sel = 1'b1; idx = 2'd0; end
            ANODE_DIGIT1: begin sel = 1'b1; idx = 2'd1; end
            ANODE_DIGIT2: begin sel = 1'b1; idx = 2'd2; end
            ANODE_DIGIT3: begin sel = 1'b1; idx = 2'd3; end
            default:      anode_err = 1'b1;
        endcase
        // The capture register holds no real sample until the first edge after reset
        if (!cap_vld_q) begin
            sel       = 1'b0;
            anode_err = 1'b0;
        end
    end

    assign accept    = sel && dec_valid;
    assign blank_sel = sel && dec_blank;
    assign any_err   = anode_err || (sel && !dec_valid && !dec_blank);

    always_comb begin
        en_d       = en_q;
        val_d      = val_q;
        cnt_d      = cnt_q;
        last_idx_d = last_idx_q;
        last_vld_d = last_vld_q;
        frame_d    = 1'b0;
        err_d      = any_err;
        sticky_d   = sticky_q | any_err;
        if (!any_err) begin
            for (int i = 0; i < 4; i++) begin
                if (accept && idx == digit_idx_t'(i)) begin
                    cnt_d[i] = '0;
                    en_d[i]  = 1'b1;
                    val_d[i] = dec_value;
                end else begin
                    if (cnt_q[i] < CNT_MAX) cnt_d[i] = cnt_q[i] + 8'd1;
                    if ((blank_sel && idx == digit_idx_t'(i)) || cnt_d[i] == CNT_MAX) begin
                        en_d[i] = 1'b0;
                    end
                end
            end
            if (accept) begin
                frame_d    = last_vld_q && (idx <= last_idx_q);
                last_idx_d = idx;
                last_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_1k_i or negedge rst_ni) begin
        if (!rst_ni) begin
            anode_q    <= '0;
            seg_q      <= '0;
            cap_vld_q  <= 1'b0;
            en_q       <= '0;
            val_q      <= '{default: '0};
            cnt_q      <= '{default: '0};
            last_idx_q <= '0;
            last_vld_q <= 1'b0;
            frame_q    <= 1'b0;
            err_q      <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            anode_q    <= anode_i;
            seg_q      <= segments_i;
            cap_vld_q  <= 1'b1;
            en_q       <= en_d;
            val_q      <= val_d;
            cnt_q      <= cnt_d;
            last_idx_q <= last_idx_d;
            last_vld_q <= last_vld_d;
            frame_q    <= frame_d;
            err_q      <= err_d;
            sticky_q   <= sticky_d;
        end
    end

    assign digit0_en_o  = en_q[0];
    assign digit1_en_o  = en_q[1];
    assign digit2_en_o  = en_q[2];
    assign digit3_en_o  = en_q[3];
    assign digit0_o     = val_q[0];
    assign digit1_o     = val_q[1];
    assign digit2_o     = val_q[2];
    assign digit3_o     = val_q[3];
    assign frame_o      = frame_q;
    assign err_o        = err_q;
    assign err_sticky_o = sticky_q;

endmodule

// File: tb/tb_basys3_7seg_capture.sv
// Scoreboard bench: a behavioural model predicts outputs for each sample driven.
module tb_basys3_7seg_capture;

    localparam int TMO = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] anode = 4'hF;
    logic [6:0] segments = 7'h7F;
    logic       en0, en1, en2, en3, frame, err, sticky;
    logic [3:0] d0, d1, d2, d3;

    basys3_7seg_capture #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_1k_i     (clk),
        .rst_ni       (rst_n),
        .anode_i      (anode),
        .segments_i   (segments),
        .digit0_en_o  (en0),
        .digit1_en_o  (en1),
        .digit2_en_o  (en2),
        .digit3_en_o  (en3),
        .digit0_o     (d0),
        .digit1_o     (d1),
        .digit2_o     (d2),
        .digit3_o     (d3),
        .frame_o      (frame),
        .err_o        (err),
        .err_sticky_o (sticky)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  en;
        logic [15:0] dig;
        logic        frame;
        logic        err;
        logic        sticky;
    } outs_t;

    // Active-high gfedcba shapes, 0..F
    logic [6:0] hex_tbl [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    outs_t      exp_q [$];
    int         checks = 0;
    int         failures = 0;
    int         frame_seen = 0;

    logic [3:0] m_en;
    logic [3:0] m_dig [4];
    int         m_cnt [4];
    int         m_last;
    logic       m_frame, m_err, m_sticky;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic outs_t dut_outs();
        outs_t o;
        o.en     = {en3, en2, en1, en0};
        o.dig    = {d3, d2, d1, d0};
        o.frame  = frame;
        o.err    = err;
        o.sticky = sticky;
        return o;
    endfunction

    function automatic outs_t model_outs();
        outs_t o;
        o.en     = m_en;
        o.dig    = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
        o.frame  = m_frame;
        o.err    = m_err;
        o.sticky = m_sticky;
        return o;
    endfunction

    task automatic model_reset();
        m_en     = '0;
        m_last   = -1;
        m_frame  = 1'b0;
        m_err    = 1'b0;
        m_sticky = 1'b0;
        for (int d = 0; d < 4; d++) begin
            m_dig[d] = '0;
            m_cnt[d] = 0;
        end
    endtask

    task automatic model_apply(input logic [3:0] an, input logic [6:0] sg);
        int         zeros;
        int         idx;
        int         val;
        logic [6:0] p;
        zeros   = 0;
        idx     = -1;
        val     = -1;
        p       = ~sg;
        m_frame = 1'b0;
        m_err   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!an[i]) begin
                zeros++;
                idx = i;
            end
        end
        if (zeros == 1) begin
            for (int k = 0; k < 16; k++) if (p == hex_tbl[k]) val = k;
        end
        if (zeros > 1 || (zeros == 1 && val < 0 && p != 7'h00)) m_err = 1'b1;
        if (m_err) begin
            m_sticky = 1'b1;
            return;
        end
        for (int d = 0; d < 4; d++) begin
            if (zeros == 1 && val >= 0 && d == idx) begin
                m_cnt[d] = 0;
                m_en[d]  = 1'b1;
                m_dig[d] = 4'(val);
            end else begin
                if (m_cnt[d] < TMO) m_cnt[d]++;
                if ((zeros == 1 && p == 7'h00 && d == idx) || m_cnt[d] >= TMO) m_en[d] = 1'b0;
            end
        end
        if (zeros == 1 && val >= 0) begin
            m_frame = (m_last >= 0) && (idx <= m_last);
            m_last  = idx;
        end
    endtask

    // Sample k is checked one edge after it is captured
    task automatic step(input logic [3:0] an, input logic [6:0] sg);
        outs_t e;
        @(negedge clk);
        anode    = an;
        segments = sg;
        model_apply(an, sg);
        exp_q.push_back(model_outs());
        @(posedge clk);
        #1;
        if (exp_q.size() > 1) begin
            e = exp_q.pop_front();
            check("outs", dut_outs(), e);
            if (frame) frame_seen++;
        end
    endtask

    task automatic show_digit(input int i, input int v);
        logic [3:0] an;
        an    = 4'hF;
        an[i] = 1'b0;
        step(an, ~hex_tbl[v]);
    endtask

    // After release: one edge processes the empty capture, the next the idle input held
    task automatic after_release();
        exp_q.delete();
        model_reset();
        model_apply(4'hF, 7'h7F);
        model_apply(4'hF, 7'h7F);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        anode    = 4'hF;
        segments = 7'h7F;
        #1;
        check("rst_outs", dut_outs(), '0);
        check("rst_sticky", sticky, 1'b0);
        #1 rst_n = 1'b1;
        after_release();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("por_outs", dut_outs(), '0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        after_release();

        // Single "5" on digit 0
        step(4'b1110, 7'b0010010);
        step(4'hF, 7'h7F);
        check("five_err", err, 1'b0);
        step(4'hF, 7'h7F);
        check("five_val", d0, 4'd5);
        check("five_en", en0, 1'b1);

        // Two passes of 1,2,3,4 from a clean reset
        pulse_reset();
        frame_seen = 0;
        for (int pass = 0; pass < 2; pass++)
            for (int i = 0; i < 4; i++) show_digit(i, i + 1);
        step(4'hF, 7'h7F);
        check("rot_frames", frame_seen, 1);
        check("rot_digits", {d3, d2, d1, d0}, 16'h4321);
        check("rot_en", {en3, en2, en1, en0}, 4'hF);

        // Digit 2 slot left idle until it times out
        for (int pass = 0; pass < 3; pass++)
            for (int i = 0; i < 4; i++) begin
                if (i == 2) step(4'hF, 7'h7F);
                else show_digit(i, i + 1);
            end
        check("tmo_en2", en2, 1'b0);
        check("tmo_d2", d2, 4'd3);
        check("tmo_others", {en3, en1, en0}, 3'b111);

        // Illegal anode, then an unknown segment shape
        step(4'b1100, 7'b0000000);
        step(4'hF, 7'h7F);
        step(4'b1110, 7'b1111110);
        step(4'hF, 7'h7F);
        step(4'hF, 7'h7F);
        check("err_sticky", sticky, 1'b1);
        check("err_d0", d0, 4'd1);

        // Reset mid-rotation, then a fresh scan
        show_digit(0, 7);
        show_digit(1, 8);
        pulse_reset();
        frame_seen = 0;
        for (int i = 2; i < 4; i++) show_digit(i, i + 10);
        for (int i = 0; i < 2; i++) show_digit(i, i + 10);
        step(4'hF, 7'h7F);
        step(4'hF, 7'h7F);
        check("post_rst_frames", frame_seen, 1);
        check("post_rst_digits", {d3, d2, d1, d0}, 16'hDCBA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
